gate_identifier: RTL and testbench

- Sequential tester for any 2-input gate in the basic gate library.
- Drives the gate's inputs through all four combinations and samples the gate's output after each one.
- Decodes the resulting 4-bit truth table into a gate-type code and compares it against an expected code.
- Sits on the driving side of the gate library, as a self-check engine for benches and the on-board test harness.

---
 rtl/gate_identifier.sv | 154 +++++++++++++++
 tb/tb_gate_identifier.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_identifier.sv
// gate_identifier: sequential self-check engine for 2-input library gates.
// Drives {a,b} through 00,01,10,11 and holds each vector for SETTLE_CYCLES
// clocks. It samples dut_y at the end of each hold, then classifies the
// resulting 4-bit truth table and compares the result with the captured
// expected code.
`timescale 1ns/1ps

module gate_identifier #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] exp_code,
  input  logic       dut_y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth_table,
  output logic [2:0] gate_code,
  output logic       pass
);

  // Terminal value of the settle counter: a sample is taken on the edge
  // where the counter already holds this value.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  // Gate-type codes reported on gate_code. The value 7 is reserved and is
  // never produced.
  localparam logic [2:0] CODE_UNKNOWN = 3'd0;
  localparam logic [2:0] CODE_AND     = 3'd1;
  localparam logic [2:0] CODE_OR      = 3'd2;
  localparam logic [2:0] CODE_NAND    = 3'd3;
  localparam logic [2:0] CODE_NOR     = 3'd4;
  localparam logic [2:0] CODE_XOR     = 3'd5;
  localparam logic [2:0] CODE_XNOR    = 3'd6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [1:0]       idx_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       exp_reg;
  logic [3:0]       tt_shadow_reg;

  logic [3:0]       tt_next;
  logic [2:0]       code_next;
  logic             pass_next;

  // Merge the current dut_y sample into the shadow table at the active
  // vector. This lets the final edge register the complete table, including
  // the last sample, in a single step.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_tt_merge
      assign tt_next[gi] = (idx_reg == 2'(gi)) ? dut_y : tt_shadow_reg[gi];
    end
  endgenerate

  // Decode the merged truth table (bit i is the output for {a,b} = i).
  always_comb begin
    code_next = CODE_UNKNOWN;
    case (tt_next)
      4'b1000: code_next = CODE_AND;
      4'b1110: code_next = CODE_OR;
      4'b0111: code_next = CODE_NAND;
      4'b0001: code_next = CODE_NOR;
      4'b0110: code_next = CODE_XOR;
      4'b1001: code_next = CODE_XNOR;
      default: code_next = CODE_UNKNOWN;
    endcase
  end

  // An unknown gate never passes, even when the expected code is also 0.
  assign pass_next = (code_next == exp_reg) && (code_next != CODE_UNKNOWN);

  // Sweep sequencer. All outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= 2'd0;
      cnt_reg       <= '0;
      exp_reg       <= 3'd0;
      tt_shadow_reg <= 4'd0;
      a             <= 1'b0;
      b             <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      truth_table   <= 4'd0;
      gate_code     <= 3'd0;
      pass          <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          a    <= 1'b0;
          b    <= 1'b0;
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            exp_reg   <= exp_code;
            idx_reg   <= 2'd0;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= DRIVE;
          end
        end

        DRIVE: begin
          if (cnt_reg != CNT_LAST) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end else begin
            cnt_reg       <= '0;
            tt_shadow_reg <= tt_next;
            if (idx_reg != 2'd3) begin
              // Advance to the next vector on the same edge as idx.
              idx_reg  <= idx_reg + 2'd1;
              {a, b}   <= idx_reg + 2'd1;
            end else begin
              // Last sample: publish the results and return the gate
              // inputs to 00.
              truth_table <= tt_next;
              gate_code   <= code_next;
              pass        <= pass_next;
              a           <= 1'b0;
              b           <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
              state_reg   <= DONE;
            end
          end
        end

        DONE: begin
          // One-cycle done pulse. A start seen here is dropped, not queued.
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_identifier.sv
// Testbench for gate_identifier. Two instances share the clock and reset:
// u=0 uses SETTLE_CYCLES=2 and u=1 uses SETTLE_CYCLES=1. Each instance has a
// "gate" modelled as a 4-bit lookup on its own {a,b} outputs.
`timescale 1ns/1ps

module tb_gate_identifier;

  logic       clk;
  logic       rst_n;
  logic [1:0] start_s;
  logic [2:0] exp_s  [2];
  logic [3:0] tt_drv [2];
  logic [1:0] dy_s;

  logic [1:0] a_s, b_s, busy_s, done_s, pass_s;
  logic [3:0] tt_o   [2];
  logic [2:0] code_o [2];

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate under test for each instance: a combinational lookup of its inputs.
  assign dy_s[0] = tt_drv[0][{a_s[0], b_s[0]}];
  assign dy_s[1] = tt_drv[1][{a_s[1], b_s[1]}];

  gate_identifier #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .exp_code(exp_s[0]),
    .dut_y(dy_s[0]), .a(a_s[0]), .b(b_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .truth_table(tt_o[0]), .gate_code(code_o[0]),
    .pass(pass_s[0])
  );

  gate_identifier #(.SETTLE_CYCLES(1), .CNT_W(4)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .exp_code(exp_s[1]),
    .dut_y(dy_s[1]), .a(a_s[1]), .b(b_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .truth_table(tt_o[1]), .gate_code(code_o[1]),
    .pass(pass_s[1])
  );

  // Reference model: build each named gate's truth table by evaluating its
  // boolean definition over all four input pairs.
  function automatic logic [3:0] gate_tt(input int code);
    logic [3:0] t;
    t = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      logic x, y;
      x = (i >= 2);
      y = (i % 2) == 1;
      case (code)
        1: t[i] = x & y;
        2: t[i] = x | y;
        3: t[i] = ~(x & y);
        4: t[i] = ~(x | y);
        5: t[i] = x ^ y;
        6: t[i] = ~(x ^ y);
        default: t[i] = 1'b0;
      endcase
    end
    return t;
  endfunction

  function automatic logic [2:0] model_code(input logic [3:0] tt);
    for (int c = 1; c <= 6; c++)
      if (gate_tt(c) == tt) return 3'(c);
    return 3'd0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // One full sweep on instance u with fixed-length (bounded) cycle checks.
  task automatic sweep(input int u, input logic [3:0] stim, input logic [2:0] ex,
                       input bit hold, input logic [3:0] e_tt,
                       input logic [2:0] e_code, input bit e_pass);
    int s;
    s = (u == 0) ? 2 : 1;
    tt_drv[u] = stim;
    @(negedge clk);
    start_s[u] = 1'b1;
    exp_s[u]   = ex;
    @(posedge clk); #1;                      // acceptance edge E0
    if (!hold) start_s[u] = 1'b0;
    exp_s[u] = ~ex;                          // expected code must be captured
    for (int m = 0; m < 4 * s; m++) begin
      chk($sformatf("busy u%0d m%0d", u, m), 32'(busy_s[u]), 32'd1);
      chk($sformatf("ab u%0d m%0d", u, m), 32'({a_s[u], b_s[u]}), 32'(m / s));
      chk($sformatf("done_early u%0d m%0d", u, m), 32'(done_s[u]), 32'd0);
      if (m == 2 * s) start_s[u] = 1'b1;     // mid-sweep start is ignored
      else if (!hold) start_s[u] = 1'b0;
      @(posedge clk); #1;
    end
    chk($sformatf("done u%0d", u), 32'(done_s[u]), 32'd1);
    chk($sformatf("busy_done u%0d", u), 32'(busy_s[u]), 32'd0);
    chk($sformatf("ab_done u%0d", u), 32'({a_s[u], b_s[u]}), 32'd0);
    chk($sformatf("tt u%0d", u), 32'(tt_o[u]), 32'(e_tt));
    chk($sformatf("code u%0d", u), 32'(code_o[u]), 32'(e_code));
    chk($sformatf("pass u%0d", u), 32'(pass_s[u]), 32'(e_pass));
    @(posedge clk); #1;                      // DONE -> IDLE, start ignored
    start_s[u] = 1'b0;
    chk($sformatf("done_pulse u%0d", u), 32'(done_s[u]), 32'd0);
    chk($sformatf("no_restart u%0d", u), 32'(busy_s[u]), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk($sformatf("persist_tt u%0d", u), 32'(tt_o[u]), 32'(e_tt));
    chk($sformatf("persist_code u%0d", u), 32'(code_o[u]), 32'(e_code));
    chk($sformatf("idle_busy u%0d", u), 32'(busy_s[u]), 32'd0);
    $display("sweep u=%0d stim=%b exp=%0d hold=%0d -> tt=%b code=%0d pass=%0d",
             u, stim, ex, hold, tt_o[u], code_o[u], pass_s[u]);
  endtask

  typedef struct {
    int         u;
    logic [3:0] stim;
    logic [2:0] ex;
    bit         hold;
    logic [3:0] e_tt;
    logic [2:0] e_code;
    bit         e_pass;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{0, 4'b1000, 3'd1, 1'b0, 4'b1000, 3'd1, 1'b1}; // AND
    vecs[1]  = '{0, 4'b0110, 3'd6, 1'b0, 4'b0110, 3'd5, 1'b0}; // XOR, wrong exp
    vecs[2]  = '{0, 4'b0110, 3'd5, 1'b0, 4'b0110, 3'd5, 1'b1}; // XOR
    vecs[3]  = '{0, 4'b1110, 3'd2, 1'b0, 4'b1110, 3'd2, 1'b1}; // OR
    vecs[4]  = '{0, 4'b0111, 3'd3, 1'b0, 4'b0111, 3'd3, 1'b1}; // NAND
    vecs[5]  = '{0, 4'b0001, 3'd4, 1'b0, 4'b0001, 3'd4, 1'b1}; // NOR
    vecs[6]  = '{0, 4'b1001, 3'd6, 1'b0, 4'b1001, 3'd6, 1'b1}; // XNOR
    vecs[7]  = '{0, 4'b0000, 3'd0, 1'b0, 4'b0000, 3'd0, 1'b0}; // tied 0
    vecs[8]  = '{0, 4'b1100, 3'd0, 1'b0, 4'b1100, 3'd0, 1'b0}; // y = a
    vecs[9]  = '{0, 4'b1000, 3'd1, 1'b1, 4'b1000, 3'd1, 1'b1}; // start held
    vecs[10] = '{1, 4'b1000, 3'd1, 1'b0, 4'b1000, 3'd1, 1'b1}; // S=1 AND
    vecs[11] = '{1, 4'b1110, 3'd3, 1'b0, 4'b1110, 3'd2, 1'b0}; // S=1 OR

    rst_n = 1'b0;
    start_s = 2'b00;
    exp_s[0] = 3'd0;  exp_s[1] = 3'd0;
    tt_drv[0] = 4'd0; tt_drv[1] = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("rst_outs u%0d", u),
          32'({a_s[u], b_s[u], busy_s[u], done_s[u], tt_o[u], code_o[u], pass_s[u]}), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 12; i++)
      sweep(vecs[i].u, vecs[i].stim, vecs[i].ex, vecs[i].hold,
            vecs[i].e_tt, vecs[i].e_code, vecs[i].e_pass);

    // Reset while vector 2 of a NAND sweep is being driven.
    tt_drv[0] = 4'b0111;
    @(negedge clk);
    start_s[0] = 1'b1;
    exp_s[0] = 3'd3;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid_ab", 32'({a_s[0], b_s[0]}), 32'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_outs",
        32'({a_s[0], b_s[0], busy_s[0], done_s[0], tt_o[0], code_o[0], pass_s[0]}), 32'd0);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin
        @(negedge clk);
        rst_n = 1'b1;
      end
      if (done_s[0] !== 1'b0 || busy_s[0] !== 1'b0)
        chk($sformatf("rst_no_done k%0d", k), 32'({busy_s[0], done_s[0]}), 32'd0);
    end
    chk("rst_after_tt", 32'(tt_o[0]), 32'd0);
    $display("reset during NAND sweep: outputs cleared, no done pulse");
    sweep(0, 4'b0111, 3'd3, 1'b0, 4'b0111, 3'd3, 1'b1);

    // Randomized sweeps checked against the behavioural model.
    for (int r = 0; r < 16; r++) begin
      int u;
      logic [3:0] stim;
      logic [2:0] ex, c;
      u = int'($urandom_range(0, 1));
      stim = 4'($urandom_range(0, 15));
      if (r % 2 == 0) stim = gate_tt(int'($urandom_range(1, 6)));
      c = model_code(stim);
      ex = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : c;
      sweep(u, stim, ex, bit'($urandom_range(0, 1)), stim, c,
            (c == ex) && (c != 3'd0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
